// File: rtl/perip_pkg.sv
// Shared definitions for the peripheral-port bus master.
// Size encodings, FSM states, lane masks and the alignment rule.
package perip_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int RD_LAT_MAX = 4;

    localparam logic [3:0] WEA_B = 4'b0001;
    localparam logic [3:0] WEA_H = 4'b0011;
    localparam logic [3:0] WEA_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        RESP
    } state_e;

    // Size 3 is never legal; half and word need natural alignment.
    function automatic logic misaligned(input logic [1:0] off,
                                        input logic [1:0] size);
        logic bad;
        bad = 1'b1;
        unique case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte-lane enables for a legal access at byte offset off.
    function automatic logic [3:0] wea_mask(input logic [1:0] off,
                                            input logic [1:0] size);
        logic [3:0] m;
        m = WEA_W;
        unique case (size)
            SIZE_B:  m = WEA_B << off;
            SIZE_H:  m = WEA_H << off;
            default: m = WEA_W;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/perip_load_align.sv
// Load data alignment: shift the word down to the addressed byte,
// truncate to the access size, then sign- or zero-extend.
module perip_load_align
    import perip_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = word >> {off, 3'b000};

    // Truncate and extend according to access size and signedness.
    always_comb begin
        result = shifted;
        unique case (size)
            SIZE_B: begin
                if (uns) result = {24'd0, shifted[7:0]};
                else     result = {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                if (uns) result = {16'd0, shifted[15:0]};
                else     result = {{16{shifted[15]}}, shifted[15:0]};
            end
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/perip_master.sv
// Single-outstanding bridge from core load/store requests to a
// peripheral port with a write port A and a registered read port B.
module perip_master
    import perip_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ena,
    output logic [31:0] addra,
    output logic [3:0]  wea,
    output logic [31:0] dina,
    output logic        enb,
    output logic [31:0] addrb,
    input  logic [31:0] doutb
);

    localparam int CW = $clog2(RD_LAT_MAX);
    localparam logic [CW-1:0] LAST = CW'(RD_LAT - 1);

    state_e        state;
    state_e        state_nx;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          accept;
    logic          bad;
    logic          last_rd;
    logic [31:0]   load_val;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign bad       = misaligned(req_addr[1:0], req_size);
    assign last_rd   = (cnt == LAST);

    perip_load_align u_align (
        .word   (doutb),
        .off    (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .result (load_val)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode; errors skip straight to the response.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = bad ? RESP : ISSUE;
            end
            ISSUE: begin
                state_nx = we_q ? RESP : RD_WAIT;
            end
            RD_WAIT: begin
                if (last_rd) state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch request attributes and count read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            off_q  <= 2'd0;
            size_q <= SIZE_B;
            uns_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                we_q   <= req_we;
                off_q  <= req_addr[1:0];
                size_q <= req_size;
                uns_q  <= req_unsigned;
            end
            if (state == ISSUE)   cnt <= '0;
            if (state == RD_WAIT) cnt <= cnt + 1'b1;
        end
    end

    // Registered port strobes and response; strobes pulse in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena       <= 1'b0;
            enb       <= 1'b0;
            wea       <= 4'd0;
            addra     <= 32'd0;
            addrb     <= 32'd0;
            dina      <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            ena <= 1'b0;
            enb <= 1'b0;
            wea <= 4'd0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else if (req_we) begin
                            ena   <= 1'b1;
                            wea   <= wea_mask(req_addr[1:0], req_size);
                            addra <= {req_addr[31:2], 2'b00};
                            dina  <= req_wdata;
                        end else begin
                            enb   <= 1'b1;
                            addrb <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                    end
                end
                RD_WAIT: begin
                    if (last_rd) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_val;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perip_master.sv
// Bench for perip_master: two instances (RD_LAT 1 and 3) driven by
// directed and random transactions against a byte-level reference.
module tb_perip_master;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        rst          [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [31:0] req_addr     [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];
    logic        ena          [2];
    logic [31:0] addra        [2];
    logic [3:0]  wea          [2];
    logic [31:0] dina         [2];
    logic        enb          [2];
    logic [31:0] addrb        [2];
    logic [31:0] doutb        [2];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          due [2];
    logic [31:0] rd_data [2];

    always #5 clk = ~clk;

    perip_master #(.RD_LAT(LAT0)) u0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .ena(ena[0]), .addra(addra[0]), .wea(wea[0]), .dina(dina[0]),
        .enb(enb[0]), .addrb(addrb[0]), .doutb(doutb[0])
    );

    perip_master #(.RD_LAT(LAT1)) u1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .ena(ena[1]), .addra(addra[1]), .wea(wea[1]), .dina(dina[1]),
        .enb(enb[1]), .addrb(addrb[1]), .doutb(doutb[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral model: data valid only RD_LAT cycles after enb,
    // random garbage on doutb at every other time.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (due[d] == cyc) doutb[d] = rd_data[d];
            else               doutb[d] = $urandom;
            if (enb[d] === 1'b1) due[d] = cyc + lat_of(d);
        end
    end

    function automatic bit is_bad(input logic [31:0] a,
                                  input logic [1:0] s);
        int nb;
        if (s == 2'd3) return 1'b1;
        nb = 1 << s;
        return (int'(a[1:0]) % nb) != 0;
    endfunction

    function automatic logic [3:0] ref_wea(input logic [31:0] a,
                                           input logic [1:0] s);
        logic [3:0] m;
        int off;
        m = 4'd0;
        off = int'(a[1:0]);
        for (int i = 0; i < (1 << s); i++) m[off + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w,
                                             input logic [31:0] a,
                                             input logic [1:0] s,
                                             input logic u);
        logic [31:0] v;
        logic [31:0] mask;
        int nb;
        nb = 1 << s;
        v = w >> (8 * int'(a[1:0]));
        if (nb < 4) begin
            mask = (32'd1 << (8 * nb)) - 32'd1;
            v = v & mask;
            if (!u && v[8 * nb - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d] = 1'b0;
            req_addr[d] = 32'd0;
            req_size[d] = 2'd0;
            req_unsigned[d] = 1'b0;
            req_wdata[d] = 32'd0;
            rsp_ready[d] = 1'b0;
        end
    endtask

    task automatic run_txn(input int d, input logic we,
                           input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [31:0] wd,
                           input logic [31:0] rw, input int hold,
                           input string nm);
        bit          bad;
        int          exp_k;
        logic [31:0] exp_rd;
        int          ena_n, enb_n, ena_k, enb_k, rsp_k;
        bit          busy_bad;
        logic [3:0]  wea_s;
        logic [31:0] addra_s, addrb_s, dina_s, rd_s;
        logic        err_s;
        bad = is_bad(a, s);
        exp_k = bad ? 1 : (we ? 2 : 2 + lat_of(d));
        exp_rd = (bad || we) ? 32'd0 : ref_load(rw, a, s, u);
        ena_n = 0; enb_n = 0; ena_k = -1; enb_k = -1; rsp_k = -1;
        busy_bad = 1'b0;
        wea_s = 4'd0; addra_s = 32'd0; addrb_s = 32'd0; dina_s = 32'd0;
        rd_data[d] = rw;
        @(negedge clk);
        checks++;
        if (req_ready[d] !== 1'b1)
            $display("FAIL %s ready_idle: got %b want 1", nm, req_ready[d]);
        req_valid[d] = 1'b1;
        req_we[d] = we;
        req_addr[d] = a;
        req_size[d] = s;
        req_unsigned[d] = u;
        req_wdata[d] = wd;
        rsp_ready[d] = 1'b0;
        for (int k = 1; k <= 12 && rsp_k < 0; k++) begin
            @(negedge clk);
            req_valid[d] = 1'b0;
            req_addr[d] = $urandom;
            req_wdata[d] = $urandom;
            if (req_ready[d] !== 1'b0) busy_bad = 1'b1;
            if (ena[d] === 1'b1) begin
                ena_n++; ena_k = k;
                wea_s = wea[d]; addra_s = addra[d]; dina_s = dina[d];
            end
            if (enb[d] === 1'b1) begin
                enb_n++; enb_k = k; addrb_s = addrb[d];
            end
            if (rsp_valid[d] === 1'b1) rsp_k = k;
        end
        checks++;
        if (rsp_k != exp_k) begin
            errors++;
            $display("FAIL %s rsp_cycle: got T+%0d want T+%0d", nm, rsp_k, exp_k);
            return;
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL %s ready_busy: req_ready high while busy", nm);
        end
        checks++;
        if (ena_n != ((we && !bad) ? 1 : 0) || enb_n != ((!we && !bad) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s strobes: ena=%0d enb=%0d pulses", nm, ena_n, enb_n);
        end
        if (we && !bad) begin
            checks++;
            if (ena_k != 1 || wea_s !== ref_wea(a, s) ||
                addra_s !== {a[31:2], 2'b00} || dina_s !== wd) begin
                errors++;
                $display("FAIL %s store_port: k=%0d wea=%b addra=%h dina=%h want wea=%b addra=%h dina=%h",
                         nm, ena_k, wea_s, addra_s, dina_s,
                         ref_wea(a, s), {a[31:2], 2'b00}, wd);
            end
        end
        if (!we && !bad) begin
            checks++;
            if (enb_k != 1 || addrb_s !== {a[31:2], 2'b00}) begin
                errors++;
                $display("FAIL %s load_port: k=%0d addrb=%h want %h",
                         nm, enb_k, addrb_s, {a[31:2], 2'b00});
            end
        end
        checks++;
        if (rsp_rdata[d] !== exp_rd || rsp_err[d] !== bad) begin
            errors++;
            $display("FAIL %s rsp_data: rdata=%h err=%b want %h %b",
                     nm, rsp_rdata[d], rsp_err[d], exp_rd, bad);
        end
        rd_s = rsp_rdata[d];
        err_s = rsp_err[d];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rd_s ||
                rsp_err[d] !== err_s || req_ready[d] !== 1'b0 ||
                ena[d] !== 1'b0 || enb[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                         nm, h, rsp_valid[d], rsp_rdata[d], rsp_err[d],
                         req_ready[d], rd_s, err_s);
            end
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s retire: valid=%b ready=%b want 0 1",
                     nm, rsp_valid[d], req_ready[d]);
        end
    endtask

    task automatic check_quiet(input int d, input string nm);
        checks++;
        if (ena[d] !== 1'b0 || enb[d] !== 1'b0 || wea[d] !== 4'd0 ||
            addra[d] !== 32'd0 || addrb[d] !== 32'd0 || dina[d] !== 32'd0 ||
            rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'd0 ||
            rsp_err[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s: ena=%b enb=%b wea=%b addra=%h addrb=%h dina=%h v=%b rd=%h e=%b rdy=%b want all 0, rdy 1",
                     nm, ena[d], enb[d], wea[d], addra[d], addrb[d], dina[d],
                     rsp_valid[d], rsp_rdata[d], rsp_err[d], req_ready[d]);
        end
    endtask

    task automatic test_reset();
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet(0, "reset_lat1");
        check_quiet(1, "reset_lat3");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check_quiet(0, "post_reset_lat1");
    endtask

    task automatic test_store();
        run_txn(0, 1'b1, 32'h0200_4000, 2'd2, 1'b0, 32'h1234_5678,
                32'h0, 0, "word_store");
        run_txn(0, 1'b1, 32'h0200_4002, 2'd0, 1'b0, 32'h0000_00AB,
                32'h0, 0, "byte_store");
        run_txn(1, 1'b1, 32'h0200_4002, 2'd1, 1'b0, 32'h0000_BEEF,
                32'h0, 0, "half_store_hi");
    endtask

    task automatic test_load();
        run_txn(0, 1'b0, 32'h0200_4002, 2'd1, 1'b0, 32'h0,
                32'h8001_0000, 0, "half_load_signed");
        run_txn(0, 1'b0, 32'h0200_4002, 2'd1, 1'b1, 32'h0,
                32'h8001_0000, 0, "half_load_unsigned");
        run_txn(0, 1'b0, 32'h0200_4003, 2'd0, 1'b0, 32'h0,
                32'h9A00_0000, 0, "byte_load_lane3");
        run_txn(1, 1'b0, 32'h0200_4008, 2'd2, 1'b0, 32'h0,
                32'hCAFE_F00D, 0, "word_load_lat3");
    endtask

    task automatic test_misalign();
        run_txn(0, 1'b0, 32'h0200_4001, 2'd2, 1'b0, 32'h0,
                32'h1111_2222, 0, "word_load_misalign");
        run_txn(0, 1'b1, 32'h0200_4003, 2'd1, 1'b0, 32'h5555_AAAA,
                32'h0, 0, "half_store_misalign");
        run_txn(1, 1'b0, 32'h0200_4000, 2'd3, 1'b0, 32'h0,
                32'h1, 0, "size3_illegal");
    endtask

    task automatic test_backpressure();
        run_txn(0, 1'b0, 32'h0200_4001, 2'd0, 1'b0, 32'h0,
                32'h0000_F300, 3, "bp_load");
        run_txn(1, 1'b0, 32'h0200_4002, 2'd2, 1'b0, 32'h0,
                32'h0, 3, "bp_err");
    endtask

    task automatic test_rst_abort();
        bit seen;
        rd_data[1] = 32'h7777_0000;
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1] = 1'b0;
        req_addr[1] = 32'h0200_4000;
        req_size[1] = 2'd2;
        req_unsigned[1] = 1'b0;
        @(negedge clk);
        req_valid[1] = 1'b0;
        checks++;
        if (enb[1] !== 1'b1) begin
            errors++;
            $display("FAIL abort_enb: got %b want 1", enb[1]);
        end
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        check_quiet(1, "abort_in_reset");
        @(negedge clk);
        rst[1] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_rsp: rsp_valid seen after abort");
        end
        run_txn(1, 1'b0, 32'h0200_4010, 2'd2, 1'b0, 32'h0,
                32'h0BAD_CAFE, 1, "load_after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int          d;
            logic [1:0]  s;
            logic [31:0] a;
            d = i % 2;
            s = 2'($urandom_range(0, 3));
            a = 32'h0200_4000 | (32'($urandom_range(0, 63)));
            run_txn(d, 1'($urandom), a, s, 1'($urandom), $urandom,
                    $urandom, $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        due[0] = -100;
        due[1] = -100;
        rd_data[0] = 32'd0;
        rd_data[1] = 32'd0;
        doutb[0] = 32'd0;
        doutb[1] = 32'd0;
        idle_all();
        test_reset();
        test_store();
        test_load();
        test_misalign();
        test_backpressure();
        test_rst_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/perip_master.md
# perip_master

Bus-master bridge that turns one core load/store request at a time into accesses on the peripheral port used by the timer/interrupt block and other memory-mapped peripherals. That port has a write port A (`ena`/`addra`/`wea`/`dina`) and a registered read port B (`enb`/`addrb`/`doutb`). The bridge sits between the core's memory stage and each peripheral. It handles byte-lane strobes, low-justified write data, read latency, load alignment and sign extension, and misalignment errors.

## Interface
- `RD_LAT`, default 1: cycles from `enb` high to `doutb` valid; legal range 1..4.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request offered.
- `req_ready` out 1: bridge accepts the request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- `req_unsigned` in 1: zero-extend loads.
- `req_wdata` in 32: store data, low-justified.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: core consumes the response.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned or illegal size.
- `ena` out 1: write strobe.
- `addra` out 32: write word address.
- `wea` out 4: byte-lane enables.
- `dina` out 32: write data.
- `enb` out 1: read strobe.
- `addrb` out 32: read word address.
- `doutb` in 32: read data from the peripheral.

## Operation
- States are IDLE, ISSUE, RD_WAIT and RESP. Reset enters IDLE.
- Acceptance happens on a cycle where `req_valid & req_ready`. The bridge latches `req_we`, `req_addr`, `req_size`, `req_unsigned` and `req_wdata`.
- Misalignment check:
  - Half requires `addr[0]==0`; word requires `addr[1:0]==0`.
  - A misaligned request or `req_size==3` goes IDLE→RESP with `rsp_err=1` and `rsp_rdata=0`.
  - No `ena` or `enb` is ever driven for such a request.
- IDLE→ISSUE on a legal acceptance. ISSUE lasts exactly one cycle.
- Store issue:
  - `ena=1`, `addra={addr[31:2],2'b00}`.
  - `wea` = 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, 1111 for word.
  - `dina=wdata` unshifted. Byte data sits in `dina[7:0]` and half data in `dina[15:0]` whatever the lane.
  - ISSUE→RESP.
- Load issue: `enb=1`, `addrb={addr[31:2],2'b00}`, then ISSUE→RD_WAIT.
- RD_WAIT counts `RD_LAT` cycles. On its last cycle it captures `doutb`, aligns it and enters RESP.
- Load alignment:
  - The captured word is shifted right by `8*addr[1:0]`.
  - The result is then truncated to the access size.
  - It is then sign-extended, or zero-extended when `req_unsigned` is set.
- RESP: `rsp_valid=1` and `rsp_rdata`/`rsp_err` are held stable until `rsp_ready`. RESP→IDLE on `rsp_valid & rsp_ready`.
- One request is outstanding at a time. A new request cannot be accepted in the same cycle a response retires, because `req_ready` goes high the cycle after.
- `ena`, `enb` and `wea` are one-cycle pulses and are 0 in every state except ISSUE. `addra`, `addrb` and `dina` hold their last values.
- All peripheral-side outputs and `rsp_*` are registered. `req_ready` is decoded from the state register.

## Timing
- Reset values:
  - `ena`, `enb`, `wea`, `addra`, `addrb`, `dina`, `rsp_valid`, `rsp_rdata` and `rsp_err` are 0.
  - `req_ready` is 1, since the block is in IDLE.
- Accept in cycle T.
- Store: `ena` high in T+1 and `rsp_valid` high from T+2.
- Load: `enb` high in T+1. Capture happens at the end of T+1+`RD_LAT`; `rsp_valid` is high from T+2+`RD_LAT`. With default settings the response arrives at T+3.
- Error: `rsp_valid` high from T+1.
- Reset asserted in any state returns to IDLE within the same cycle. Any in-flight strobe is dropped and no response is produced for the aborted request.
- `doutb` is sampled only in the final RD_WAIT cycle. Its value at any other time is ignored.

## Structure
- Shared package `perip_pkg` holds:
  - the size encodings (`SIZE_B`, `SIZE_H`, `SIZE_W`);
  - the state enum;
  - `RD_LAT_MAX=4`;
  - the wea lane-mask constants.
- One combinational sub-module, `perip_load_align`, takes (word, `addr[1:0]`, size, unsigned) and produces the extended result. It is reused by the core LSU.
- The FSM, latency counter and registers live in `perip_master`.

## Test plan
- Word store, addr 0x0200_4000, data 0x1234_5678 → `ena` high exactly in T+1 with `wea`=1111, `addra`=0x0200_4000, `dina`=0x1234_5678; `rsp_valid` at T+2 with `rsp_err`=0.
- Byte store, addr 0x0200_4002, data 0x0000_00AB → `wea`=0100, `addra`=0x0200_4000, `dina[7:0]`=0xAB.
- Signed half load, addr 0x0200_4002, model `doutb`=0x8001_0000 with `RD_LAT`=1 → `enb` at T+1; `rsp_rdata`=0xFFFF_8001 at T+3. The same load with `req_unsigned` set → 0x0000_8001.
- Word load at 0x0200_4001 → `rsp_err`=1 and `rsp_rdata`=0 at T+1; `ena` and `enb` never assert.
- Backpressure: hold `rsp_ready` low for 3 cycles → `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable and `req_ready` stays 0. Retire, then `req_ready`=1 the next cycle.
- `RD_LAT`=3 load, with `rst` pulsed during RD_WAIT → no `rsp_valid`, all outputs 0 and `req_ready`=1 after reset. A following word load returns the correct data at T+5.
